// File: rtl/dma_pkg.sv
// Shared register map, mode-bit layout and transfer-type encoding for the DMA
// address/count datapath.
package dma_pkg;

   localparam logic [2:0] REG_SRC  = 3'd0;
   localparam logic [2:0] REG_DST  = 3'd1;
   localparam logic [2:0] REG_CNT  = 3'd2;
   localparam logic [2:0] REG_MODE = 3'd3;
   localparam logic [2:0] REG_STAT = 3'd4;

   localparam int MODE_TYPE_LSB = 0;
   localparam int MODE_AUTOINIT = 2;
   localparam int MODE_SRC_DEC  = 3;
   localparam int MODE_DST_DEC  = 4;

   localparam int STAT_TC = 0;

   typedef enum logic [1:0] {
      XFER_NONE       = 2'b00,
      XFER_IO_TO_MEM  = 2'b01,
      XFER_MEM_TO_IO  = 2'b10,
      XFER_MEM_TO_MEM = 2'b11
   } xfer_t;

endpackage

// File: rtl/dma_address_count_unit_if.sv
// CPU programming bus, FSM state strobes and memory-side signals of the DMA
// address/count unit.
interface dma_address_count_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              program_mode;
   logic [2:0]        reg_sel;
   logic              reg_wr;
   logic              reg_rd;
   logic [DATA_W-1:0] reg_din;
   logic [DATA_W-1:0] reg_dout;
   logic              state_read;
   logic              state_write;
   logic              state_done;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic              mem_dout_en;
   logic [ADDR_W-1:0] addr_out;
   logic              io_to_mem;
   logic              mem_to_io;
   logic              mem_to_mem;
   logic              terminal_count;

   modport slave (
      input  program_mode, reg_sel, reg_wr, reg_rd, reg_din,
      input  state_read, state_write, state_done, mem_din,
      output reg_dout, mem_dout, mem_dout_en, addr_out,
      output io_to_mem, mem_to_io, mem_to_mem, terminal_count
   );

   modport master (
      output program_mode, reg_sel, reg_wr, reg_rd, reg_din,
      output state_read, state_write, state_done, mem_din,
      input  reg_dout, mem_dout, mem_dout_en, addr_out,
      input  io_to_mem, mem_to_io, mem_to_mem, terminal_count
   );
endinterface

// File: rtl/dma_base_current_reg.sv
// Base/current register pair: byte-wise program load into both, reload of
// current from base, and +/-1 stepping of current with modulo wrap.
module dma_base_current_reg #(
   parameter int W      = 16,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ld_lo,
   input  logic              ld_hi,
   input  logic [DATA_W-1:0] din,
   input  logic              reload,
   input  logic              step,
   input  logic              step_dn,
   output logic [W-1:0]      cur_q
);

   localparam int PW = 2 * DATA_W;

   logic [W-1:0] base_q;
   logic [W-1:0] loaded;

   function automatic logic [W-1:0] put_byte(input logic [W-1:0] v,
                                             input logic hi,
                                             input logic [DATA_W-1:0] b);
      logic [PW-1:0] p;
      p = PW'(v);
      if (hi) p[PW-1:DATA_W] = b;
      else    p[DATA_W-1:0]  = b;
      return W'(p);
   endfunction

   assign loaded = put_byte(base_q, ld_hi, din);

   // A program write wins over reload/step on this register in the same cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         base_q <= '0;
         cur_q  <= '0;
      end else if (ld_lo || ld_hi) begin
         base_q <= loaded;
         cur_q  <= loaded;
      end else if (reload) begin
         cur_q <= base_q;
      end else if (step) begin
         cur_q <= cur_q + (step_dn ? {W{1'b1}} : W'(1));
      end
   end

endmodule

// File: rtl/dma_address_count_unit.sv
// Datapath beside the DMA timing FSM: programmable source/destination/count
// registers, mode decode, per-transfer stepping, terminal count and temp byte.
module dma_address_count_unit
   import dma_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int COUNT_W = 16,
   parameter int DATA_W  = 8
) (
   input logic                 CLK,
   input logic                 RESET,
   dma_address_count_unit_if.slave bus
);

   localparam int PW = 2 * DATA_W;

   logic               wr_ok, rd_ok, byte_access;
   logic               bp_q, tc_flag_q;
   logic [DATA_W-1:0]  mode_q, tmp_q, status;
   logic [ADDR_W-1:0]  src_cur, dst_cur;
   logic [COUNT_W-1:0] cnt_cur;
   xfer_t              xfer;
   logic               is_m2m, cnt_zero, tc_evt, reload;

   function automatic logic [DATA_W-1:0] pick_byte(input logic [PW-1:0] v,
                                                   input logic hi);
      return hi ? v[PW-1:DATA_W] : v[DATA_W-1:0];
   endfunction

   assign wr_ok       = bus.program_mode & bus.reg_wr;
   assign rd_ok       = bus.program_mode & bus.reg_rd;
   assign byte_access = (wr_ok | rd_ok) &
                        (bus.reg_sel inside {REG_SRC, REG_DST, REG_CNT});

   assign xfer     = xfer_t'(mode_q[MODE_TYPE_LSB +: 2]);
   assign is_m2m   = (xfer == XFER_MEM_TO_MEM);
   assign cnt_zero = (cnt_cur == '0);
   assign tc_evt   = bus.state_done & cnt_zero;
   assign reload   = tc_evt & mode_q[MODE_AUTOINIT];

   dma_base_current_reg #(.W(ADDR_W), .DATA_W(DATA_W)) u_src (
      .CLK(CLK), .RESET(RESET),
      .ld_lo(wr_ok && bus.reg_sel == REG_SRC && !bp_q),
      .ld_hi(wr_ok && bus.reg_sel == REG_SRC &&  bp_q),
      .din(bus.reg_din), .reload(reload),
      .step(bus.state_done), .step_dn(mode_q[MODE_SRC_DEC]),
      .cur_q(src_cur)
   );

   // Destination only advances on memory-to-memory transfers.
   dma_base_current_reg #(.W(ADDR_W), .DATA_W(DATA_W)) u_dst (
      .CLK(CLK), .RESET(RESET),
      .ld_lo(wr_ok && bus.reg_sel == REG_DST && !bp_q),
      .ld_hi(wr_ok && bus.reg_sel == REG_DST &&  bp_q),
      .din(bus.reg_din), .reload(reload),
      .step(bus.state_done && is_m2m), .step_dn(mode_q[MODE_DST_DEC]),
      .cur_q(dst_cur)
   );

   // Decrementing from zero without autoinit wraps the count to all ones.
   dma_base_current_reg #(.W(COUNT_W), .DATA_W(DATA_W)) u_cnt (
      .CLK(CLK), .RESET(RESET),
      .ld_lo(wr_ok && bus.reg_sel == REG_CNT && !bp_q),
      .ld_hi(wr_ok && bus.reg_sel == REG_CNT &&  bp_q),
      .din(bus.reg_din), .reload(reload),
      .step(bus.state_done), .step_dn(1'b1),
      .cur_q(cnt_cur)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         bp_q      <= 1'b0;
         tc_flag_q <= 1'b0;
         mode_q    <= '0;
         tmp_q     <= '0;
      end else begin
         if (wr_ok && bus.reg_sel == REG_STAT) bp_q <= 1'b0;
         else if (byte_access)                 bp_q <= ~bp_q;

         if (tc_evt)                                tc_flag_q <= 1'b1;
         else if (rd_ok && bus.reg_sel == REG_STAT) tc_flag_q <= 1'b0;

         if (wr_ok && bus.reg_sel == REG_MODE) mode_q <= bus.reg_din;

         // Every read-state cycle reloads, so the final (post wait-state) byte is kept.
         if (bus.state_read && is_m2m) tmp_q <= bus.mem_din;
      end
   end

   always_comb begin
      status          = '0;
      status[STAT_TC] = tc_flag_q;
   end

   always_comb begin
      bus.reg_dout = '0;
      case (bus.reg_sel)
         REG_SRC:  bus.reg_dout = pick_byte(PW'(src_cur), bp_q);
         REG_DST:  bus.reg_dout = pick_byte(PW'(dst_cur), bp_q);
         REG_CNT:  bus.reg_dout = pick_byte(PW'(cnt_cur), bp_q);
         REG_MODE: bus.reg_dout = mode_q;
         REG_STAT: bus.reg_dout = status;
         default:  bus.reg_dout = '0;
      endcase
   end

   assign bus.mem_dout_en    = bus.state_write & is_m2m;
   assign bus.mem_dout       = bus.mem_dout_en ? tmp_q : '0;
   assign bus.addr_out       = bus.mem_dout_en ? dst_cur : src_cur;
   assign bus.io_to_mem      = (xfer == XFER_IO_TO_MEM);
   assign bus.mem_to_io      = (xfer == XFER_MEM_TO_IO);
   assign bus.mem_to_mem     = is_m2m;
   assign bus.terminal_count = tc_evt;

endmodule
